fifo_param: RTL and testbench
=============================

// Module: fifo_param
// PURPOSE
//  Parametrised synchronous single-clock FIFO and successor to the fixed 8-bit FIFO.
//  - Generalised data width and depth.
//  - Occupancy count and programmable almost-full / almost-empty flags.
//  - Sticky overflow/underflow error flags.
//  - Selectable read mode: first-word fall-through or registered.
//  Sits between byte/word producers and consumers (UART, SPI, display paths) on the FPGA boards.
// PARAMETERS
//  WIDTH      8                data word width, >= 1
//  DEPTH      16               entries; power of 2, >= 2
//  AF_LEVEL   DEPTH-1          almost_full  = (count >= AF_LEVEL); 1..DEPTH
//  AE_LEVEL   1                almost_empty = (count <= AE_LEVEL); 0..DEPTH-1
//  FWFT       1                1 = fall-through read, 0 = registered read (1-cycle latency)
//  ADDR_WIDTH $clog2(DEPTH)    derived; do not override
// PORTS
//  clk           in   1             clock, all logic on posedge
//  rst           in   1             synchronous reset, active-high
//  wr_en         in   1             write request
//  wdata         in   WIDTH         write data
//  rd_en         in   1             read (pop) request
//  rdata         out  WIDTH         read data
//  rd_valid      out  1             rdata holds a valid word
//  empty         out  1             count == 0
//  full          out  1             count == DEPTH
//  almost_empty  out  1             count <= AE_LEVEL
//  almost_full   out  1             count >= AF_LEVEL
//  count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  overflow      out  1             sticky: a write was dropped
//  underflow     out  1             sticky: a read was ignored
//  clr_err       in   1             clears overflow/underflow
// BEHAVIOUR
//  - Reset (rst=1 at posedge; overrides all inputs, valid mid-operation; memory contents not cleared):
//      waddr=raddr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0,
//      overflow=underflow=0, rd_valid=0, rdata=0.
//  - Accepts: wr_ok = wr_en & (!full | rd_en); rd_ok = rd_en & !empty.
//      Pointers wrap naturally modulo DEPTH.
//  - Count update: count_next = count + wr_ok - rd_ok.
//      Flags are derived combinationally from registered count, so they change the cycle after the posedge that changes count.
//  - Full and wr_en & rd_en: both accepted; count stays DEPTH; the popped word is the old head.
//  - Empty and wr_en & rd_en: write accepted, read ignored, underflow set; count becomes 1.
//  - Full and wr_en & !rd_en: write dropped, memory unchanged, overflow set.
//  - Empty and rd_en: read ignored, underflow set.
//  - Sticky flags:
//      set on the posedge after the offending request; held until rst, or clr_err at a posedge.
//      If clr_err and a new error occur in the same cycle, the flag is set (set wins).
//  - FWFT=1:
//      rdata = mem[raddr] combinationally when !empty, else 0.
//      rd_valid = !empty.
//      rd_en pops the displayed word at the posedge.
//  - FWFT=0:
//      On the posedge where rd_ok: rdata <= mem[raddr] and rd_valid <= 1.
//      Otherwise rd_valid <= 0 and rdata holds its value.
//      Latency is 1 cycle from rd_en to data.
//  - Write-to-read latency:
//      FWFT=1: a word written at edge N is visible on rdata after edge N (empty drops after N).
//      FWFT=0: earliest rd_ok is at edge N+1.
// STRUCTURE
//  - Package fifo_pkg: mode constants FIFO_MODE_FWFT=1 / FIFO_MODE_REG=0;
//    function fifo_cnt_w(depth) = $clog2(depth)+1.
//  - Sub-module fifo_ram #(WIDTH, DEPTH):
//      simple dual-port array; synchronous write, asynchronous read; infers distributed/LUT RAM.
//  - fifo_param holds pointers, count, flags, error logic and the FWFT/registered output stage.
//  - Elaboration checks ($error): DEPTH power of 2, AF_LEVEL and AE_LEVEL within their ranges.
// TESTING (bench tb_fifo_param, DEPTH=4, WIDTH=8, AF=3, AE=1 unless noted)
//  1. Reset, then write 0x11,0x22,0x33,0x44
//       -> count 1,2,3,4; almost_full at count 3; full at 4; empty falls after the first write.
//  2. Full, then write 0x55 alone
//       -> overflow=1, count=4; reads return 0x11..0x44 in order, empty=1 after the 4th pop.
//  3. Full, then wr_en & rd_en with 0x66
//       -> rdata 0x11 popped, count stays 4; subsequent order 0x22,0x33,0x44,0x66 (pointer wrap).
//  4. Empty, then wr_en & rd_en with 0x77
//       -> underflow=1, count=1, rdata=0x77; clr_err pulse -> underflow=0.
//  5. FWFT=0: write 0xA5, then rd_en for 1 cycle
//       -> rd_valid=1 and rdata=0xA5 exactly one cycle after rd_en; rd_valid=0 the following cycle.
//  6. Assert rst with count=3 and wr_en high
//       -> next cycle count=0, empty=1, flags cleared, write ignored.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO.
package fifo_pkg;

   localparam int FIFO_MODE_FWFT = 1;
   localparam int FIFO_MODE_REG  = 0;

   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy flags, sticky errors
// and a selectable fall-through or registered read port.
module fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 1,
   parameter int AE_LEVEL   = 1,
   parameter int FWFT       = FIFO_MODE_FWFT,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rdata,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int CW = fifo_cnt_w(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("fifo_param: DEPTH must be a power of 2 and >= 2");
   end
   if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_chk_af
      $error("fifo_param: AF_LEVEL out of range 1..DEPTH");
   end
   if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_chk_ae
      $error("fifo_param: AE_LEVEL out of range 0..DEPTH-1");
   end

   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  wr_ok, rd_ok;
   logic [WIDTH-1:0]      ram_rdata;

   assign empty        = (count_q == '0);
   assign full         = (count_q == CW'(DEPTH));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   // A full FIFO still takes a write when the same edge pops the head.
   assign wr_ok = wr_en & (!full | rd_en);
   assign rd_ok = rd_en & !empty;

   always_comb begin
      waddr_d = waddr_q;
      raddr_d = raddr_q;
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
      ovf_d   = ovf_q & !clr_err;
      udf_d   = udf_q & !clr_err;
      if (wr_ok) waddr_d = waddr_q + 1'b1;
      if (rd_ok) raddr_d = raddr_q + 1'b1;
      if (wr_en & !wr_ok) ovf_d = 1'b1;
      if (rd_en & empty)  udf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         waddr_q <= '0;
         raddr_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         waddr_q <= waddr_d;
         raddr_q <= raddr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (waddr_q),
      .wdata (wdata),
      .raddr (raddr_q),
      .rdata (ram_rdata)
   );

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign rdata    = empty ? '0 : ram_rdata;
      assign rd_valid = !empty;
   end else begin : g_reg
      logic [WIDTH-1:0] rdata_q;
      logic             rd_valid_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= rd_ok;
            if (rd_ok) rdata_q <= ram_rdata;
         end
      end

      assign rdata    = rdata_q;
      assign rd_valid = rd_valid_q;
   end

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: fall-through and registered instances share stimulus.
module tb_fifo_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wdata = '0;
   logic       rd_en = 1'b0;
   logic       clr_err = 1'b0;

   logic [7:0] rdata1, rdata0;
   logic       rv1, rv0, em1, em0, fu1, fu0;
   logic       ae1, ae0, af1, af0, ov1, ov0, un1, un0;
   logic [2:0] cnt1, cnt0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_param #(
      .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)
   ) d1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata),
      .rd_en(rd_en), .rdata(rdata1), .rd_valid(rv1),
      .empty(em1), .full(fu1), .almost_empty(ae1),
      .almost_full(af1), .count(cnt1), .overflow(ov1),
      .underflow(un1), .clr_err(clr_err)
   );

   fifo_param #(
      .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)
   ) d0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata),
      .rd_en(rd_en), .rdata(rdata0), .rd_valid(rv0),
      .empty(em0), .full(fu0), .almost_empty(ae0),
      .almost_full(af0), .count(cnt0), .overflow(ov0),
      .underflow(un0), .clr_err(clr_err)
   );

   // Reference model: a queue of stored words plus sticky bits.
   logic [7:0] mq[$];
   bit         m_ov, m_un, m_v0;
   logic [7:0] m_r0;

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, a, e, $time);
      end
   endtask

   task automatic model_step(input bit rs, input bit w,
                             input logic [7:0] d, input bit r,
                             input bit c);
      int n;
      bit wok, rok, was_full, was_empty;
      logic [7:0] pop;
      n = mq.size();
      if (rs) begin
         mq.delete();
         m_ov = 0; m_un = 0; m_v0 = 0; m_r0 = '0;
         return;
      end
      was_full  = (n == 4);
      was_empty = (n == 0);
      wok = w && (!was_full || r);
      rok = r && !was_empty;
      pop = '0;
      if (rok) pop = mq.pop_front();
      if (wok) mq.push_back(d);
      m_ov = (w && !wok) || (m_ov && !c);
      m_un = (r && was_empty) || (m_un && !c);
      m_v0 = rok;
      if (rok) m_r0 = pop;
   endtask

   task automatic model_check();
      int n;
      logic [7:0] head;
      n = mq.size();
      head = (n != 0) ? mq[0] : 8'h00;
      chk("count1", 32'(cnt1), 32'(n));
      chk("count0", 32'(cnt0), 32'(n));
      chk("empty1", 32'(em1), 32'(n == 0));
      chk("empty0", 32'(em0), 32'(n == 0));
      chk("full1", 32'(fu1), 32'(n == 4));
      chk("aempty1", 32'(ae1), 32'(n <= 1));
      chk("afull1", 32'(af1), 32'(n >= 3));
      chk("ovf1", 32'(ov1), 32'(m_ov));
      chk("udf1", 32'(un1), 32'(m_un));
      chk("ovf0", 32'(ov0), 32'(m_ov));
      chk("udf0", 32'(un0), 32'(m_un));
      chk("rdata1", 32'(rdata1), 32'(head));
      chk("rvalid1", 32'(rv1), 32'(n != 0));
      chk("rdata0", 32'(rdata0), 32'(m_r0));
      chk("rvalid0", 32'(rv0), 32'(m_v0));
   endtask

   task automatic cyc(input bit rs, input bit w, input logic [7:0] d,
                      input bit r, input bit c);
      rst = rs; wr_en = w; wdata = d; rd_en = r; clr_err = c;
      model_step(rs, w, d, r, c);
      @(posedge clk);
      #1;
      model_check();
   endtask

   typedef struct {
      bit         rs, w;
      logic [7:0] d;
      bit         r, c;
      int         cnt;
      logic [7:0] rd;
      bit         ov, un;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(bit rs, bit w, logic [7:0] d, bit r,
                               bit c, int cnt, logic [7:0] rd,
                               bit ov, bit un);
      vec_t v;
      v.rs = rs; v.w = w; v.d = d; v.r = r; v.c = c;
      v.cnt = cnt; v.rd = rd; v.ov = ov; v.un = un;
      return v;
   endfunction

   initial begin
      // rs  w  d      r  c   cnt rdata1 ov un
      tv.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
      tv.push_back(mk(0, 1, 8'h11, 0, 0, 1, 8'h11, 0, 0));
      tv.push_back(mk(0, 1, 8'h22, 0, 0, 2, 8'h11, 0, 0));
      tv.push_back(mk(0, 1, 8'h33, 0, 0, 3, 8'h11, 0, 0));
      tv.push_back(mk(0, 1, 8'h44, 0, 0, 4, 8'h11, 0, 0));
      tv.push_back(mk(0, 1, 8'h55, 0, 0, 4, 8'h11, 1, 0));
      tv.push_back(mk(0, 0, 8'h00, 1, 0, 3, 8'h22, 1, 0));
      tv.push_back(mk(0, 0, 8'h00, 1, 0, 2, 8'h33, 1, 0));
      tv.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h44, 1, 0));
      tv.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0));
      tv.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0));
      tv.push_back(mk(0, 1, 8'h11, 0, 0, 1, 8'h11, 0, 0));
      tv.push_back(mk(0, 1, 8'h22, 0, 0, 2, 8'h11, 0, 0));
      tv.push_back(mk(0, 1, 8'h33, 0, 0, 3, 8'h11, 0, 0));
      tv.push_back(mk(0, 1, 8'h44, 0, 0, 4, 8'h11, 0, 0));
      tv.push_back(mk(0, 1, 8'h66, 1, 0, 4, 8'h22, 0, 0));
      tv.push_back(mk(0, 0, 8'h00, 1, 0, 3, 8'h33, 0, 0));
      tv.push_back(mk(0, 0, 8'h00, 1, 0, 2, 8'h44, 0, 0));
      tv.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h66, 0, 0));
      tv.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
      tv.push_back(mk(0, 1, 8'h77, 1, 0, 1, 8'h77, 0, 1));
      tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h77, 0, 0));
      tv.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
      tv.push_back(mk(0, 1, 8'h01, 0, 0, 1, 8'h01, 0, 0));
      tv.push_back(mk(0, 1, 8'h02, 0, 0, 2, 8'h01, 0, 0));
      tv.push_back(mk(0, 1, 8'h03, 0, 0, 3, 8'h01, 0, 0));
      tv.push_back(mk(1, 1, 8'h04, 0, 0, 0, 8'h00, 0, 0));

      repeat (2) @(posedge clk);
      #1;

      foreach (tv[i]) begin
         cyc(tv[i].rs, tv[i].w, tv[i].d, tv[i].r, tv[i].c);
         chk($sformatf("vec%0d_cnt", i), 32'(cnt1), 32'(tv[i].cnt));
         chk($sformatf("vec%0d_rd", i), 32'(rdata1), 32'(tv[i].rd));
         chk($sformatf("vec%0d_ov", i), 32'(ov1), 32'(tv[i].ov));
         chk($sformatf("vec%0d_un", i), 32'(un1), 32'(tv[i].un));
      end

      // Full with simultaneous push/pop: registered port shows old head.
      cyc(0, 1, 8'hB1, 0, 0);
      cyc(0, 1, 8'hB2, 0, 0);
      cyc(0, 1, 8'hB3, 0, 0);
      cyc(0, 1, 8'hB4, 0, 0);
      cyc(0, 1, 8'hB5, 1, 0);
      chk("fullrw_rd0", 32'(rdata0), 32'h0B1);
      chk("fullrw_cnt", 32'(cnt0), 32'd4);

      // Registered read latency with a single word.
      cyc(1, 0, 8'h00, 0, 0);
      cyc(0, 1, 8'hA5, 0, 0);
      chk("reg_nowrd_v", 32'(rv0), 32'd0);
      cyc(0, 0, 8'h00, 1, 0);
      chk("reg_lat_v", 32'(rv0), 32'd1);
      chk("reg_lat_d", 32'(rdata0), 32'h0A5);
      cyc(0, 0, 8'h00, 0, 0);
      chk("reg_drop_v", 32'(rv0), 32'd0);
      chk("reg_hold_d", 32'(rdata0), 32'h0A5);

      // Clear and new error in the same cycle: set wins.
      cyc(0, 0, 8'h00, 1, 0);
      cyc(0, 0, 8'h00, 1, 1);
      chk("setwins_un", 32'(un1), 32'd1);

      for (int k = 0; k < 600; k++) begin
         cyc(($urandom_range(0, 49) == 0),
             ($urandom_range(0, 99) < 55), 8'($urandom),
             ($urandom_range(0, 99) < 50),
             ($urandom_range(0, 9) == 0));
      end

      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
